// File: rtl/btn_pulse_gen_if.sv
// btn_pulse_gen_if: command bus from the button front-end to the calculator core
interface btn_pulse_gen_if;
    logic [3:0] num_o;
    logic       busy;
    logic [3:0] stable_o;
    modport master (output num_o, busy, stable_o);
    modport slave  (input  num_o, busy, stable_o);
endinterface

// File: rtl/btn_pulse_gen.sv
// btn_pulse_gen: synchronise and debounce four buttons, emit one-hot single-cycle command pulses.
// Define BTN_AUTO_REPEAT_EN to auto-repeat bit0 (increment) while it is held.
module btn_pulse_gen #(
    parameter int DB_CYCLES  = 16,
    parameter int GAP_CYCLES = 1,
    parameter int RPT_DELAY  = 64,
    parameter int RPT_PERIOD = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      btn_raw,
    btn_pulse_gen_if.master bus
);
    localparam int DBW = $clog2(DB_CYCLES + 1);
    localparam int GW  = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

    state_t              state_q, state_d;
    logic [3:0]          meta_q, sync_q;
    logic [3:0]          stable_q, stable_d;
    logic [3:0][DBW-1:0] cnt_q, cnt_d;
    logic [3:0]          pend_q, pend_d;
    logic [3:0]          num_q, num_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic [3:0]          rise, sel, clr;
    logic                rpt;

    if (DB_CYCLES < 2 || GAP_CYCLES < 1 || RPT_PERIOD < 1 || RPT_DELAY < RPT_PERIOD) begin : g_bad_cfg
        $error("btn_pulse_gen: invalid parameter set");
    end

    // Debounce: a level change is accepted after DB_CYCLES consecutive differing samples.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (sync_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DBW'(DB_CYCLES - 1)) begin
                cnt_d[i]    = '0;
                stable_d[i] = ~stable_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + DBW'(1);
            end
        end
    end

    assign rise = stable_d & ~stable_q;
    assign sel  = pend_q[3] ? 4'b1000 :
                  pend_q[2] ? 4'b0100 :
                  pend_q[1] ? 4'b0010 :
                  pend_q[0] ? 4'b0001 : 4'b0000;

    // Output FSM: a pulse, GAP_CYCLES idle cycles, then the next pending command straight away.
    always_comb begin
        state_d = state_q;
        num_d   = '0;
        gap_d   = gap_q;
        clr     = '0;
        if (state_q == PULSE) begin
            state_d = GAP;
            gap_d   = GW'(GAP_CYCLES - 1);
        end else if (state_q == GAP && gap_q != '0) begin
            gap_d = gap_q - GW'(1);
        end else if (|pend_q) begin
            state_d = PULSE;
            num_d   = sel;
            clr     = sel[3] ? 4'hf : sel;
        end else begin
            state_d = IDLE;
        end
    end

`ifdef BTN_AUTO_REPEAT_EN
    localparam int HW = $clog2(RPT_DELAY + 1);
    logic [HW-1:0] hold_q, hold_d;

    // Hold timer: cycles since stable[0] rose, reloaded after each repeat so later ones follow every RPT_PERIOD.
    always_comb begin
        hold_d = '0;
        rpt    = 1'b0;
        if (stable_q[0] && !clr[3]) begin
            hold_d = hold_q + HW'(1);
            if (hold_d == HW'(RPT_DELAY)) begin
                rpt    = 1'b1;
                hold_d = HW'(RPT_DELAY - RPT_PERIOD);
            end
        end
    end

    // Hold timer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hold_q <= '0;
        else        hold_q <= hold_d;
    end
`else
    assign rpt = 1'b0;
`endif

    assign pend_d = (pend_q & ~clr) | rise | {3'b000, rpt};

    // State registers: synchroniser, debounce, pending flags and FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q   <= '0;
            sync_q   <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
            pend_q   <= '0;
            num_q    <= '0;
            gap_q    <= '0;
            state_q  <= IDLE;
        end else begin
            meta_q   <= btn_raw;
            sync_q   <= meta_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            num_q    <= num_d;
            gap_q    <= gap_d;
            state_q  <= state_d;
        end
    end

    assign bus.num_o    = num_q;
    assign bus.busy     = (state_q != IDLE) | (|pend_q);
    assign bus.stable_o = stable_q;
endmodule

// File: tb/tb_btn_pulse_gen.sv
// tb_btn_pulse_gen: directed and randomized checks of btn_pulse_gen against a timestamp-based model
module tb_btn_pulse_gen;
    localparam int DB  = 4;
    localparam int GAP = 1;
    localparam int RD  = 8;
    localparam int RP  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn_raw = 4'b0;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;

    btn_pulse_gen_if bus();

    btn_pulse_gen #(.DB_CYCLES(DB), .GAP_CYCLES(GAP), .RPT_DELAY(RD), .RPT_PERIOD(RP)) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: pins pass a 2-stage delay line, a level is accepted after DB equal
    // samples, and the emitter may fire whenever the cycle index has reached next_ok.
    logic [3:0] m_s1, m_s2, m_stable, m_pend, m_num;
    int         m_run [4];
    int         m_next_ok, m_rise0;

    always @(posedge clk or negedge rst_n) begin : model
        logic [3:0] rises;
        logic       fire;
`ifdef BTN_AUTO_REPEAT_EN
        int         e;
`endif
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_pend = '0; m_num = '0;
            m_run = '{default: 0};
            m_next_ok = 0; m_rise0 = 0;
        end else begin
            cyc++;
            m_num = '0;
            if (m_pend != '0 && cyc >= m_next_ok) begin
                for (int b = 3; b >= 0; b--) if (m_pend[b] && m_num == '0) m_num[b] = 1'b1;
                m_pend = m_num[3] ? 4'h0 : (m_pend & ~m_num);
                if (m_num[3]) m_rise0 = cyc;
                m_next_ok = cyc + 1 + GAP;
            end
            fire = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
            e = cyc - m_rise0;
            if (m_stable[0] && !m_num[3] && e >= RD && (e - RD) % RP == 0) fire = 1'b1;
`endif
            rises = '0;
            for (int i = 0; i < 4; i++) begin
                if (m_s2[i] != m_stable[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_stable[i] = ~m_stable[i];
                        m_run[i] = 0;
                        rises[i] = m_stable[i];
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            if (rises[0]) m_rise0 = cyc;
            m_pend = m_pend | rises | {3'b000, fire};
            m_s2 = m_s1;
            m_s1 = btn_raw;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        tick(3);
        total++; if (bus.num_o !== 4'b0) begin bad++; $display("FAIL reset_num got=%b exp=0000", bus.num_o); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        total++; if (bus.stable_o !== 4'b0) begin bad++; $display("FAIL reset_stable got=%b exp=0000", bus.stable_o); end
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_single;
        int lat = 0;
        int extra = 0;
        btn_raw = 4'b0001;
        while (bus.num_o === 4'b0 && lat < 30) begin
            tick();
            lat++;
        end
        total++; if (lat !== 7) begin bad++; $display("FAIL single_latency got=%0d exp=7", lat); end
        total++; if (bus.num_o !== 4'b0001) begin bad++; $display("FAIL single_value got=%b exp=0001", bus.num_o); end
        tick();
        total++; if (bus.num_o !== 4'b0) begin bad++; $display("FAIL single_width got=%b exp=0000", bus.num_o); end
        for (int k = 0; k < 40; k++) begin
            if (lat + 1 + k == 20) btn_raw = 4'b0;
            tick();
            if (bus.num_o !== 4'b0) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL single_extra got=%0d exp=0", extra); end
    endtask

    task automatic test_bounce;
        for (int k = 0; k < 22; k++) begin
            btn_raw = (k < 12 && (k / 2) % 2 == 0) ? 4'b0001 : 4'b0000;
            tick();
            total++; if (bus.num_o !== 4'b0) begin bad++; $display("FAIL bounce_num got=%b exp=0000", bus.num_o); end
            total++; if (bus.stable_o !== 4'b0) begin bad++; $display("FAIL bounce_stable got=%b exp=0000", bus.stable_o); end
        end
    endtask

    task automatic test_simultaneous;
        int pt[$];
        logic [3:0] pv[$];
        btn_raw = 4'b0111;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (bus.num_o !== 4'b0) begin pv.push_back(bus.num_o); pt.push_back(k); end
        end
        total++;
        if (pv.size() != 3 || {pv[0], pv[1], pv[2]} !== 12'b0100_0010_0001) begin
            bad++; $display("FAIL simul_order got_n=%0d exp_n=3 exp=0100,0010,0001", pv.size());
        end
        total++;
        if (pt.size() != 3 || pt[1] - pt[0] != 2 || pt[2] - pt[1] != 2) begin
            bad++; $display("FAIL simul_spacing got_n=%0d exp spacing 2", pt.size());
        end
        btn_raw = 4'b0;
        tick(20);
        pv.delete();
        btn_raw = 4'b1111;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (bus.num_o !== 4'b0) pv.push_back(bus.num_o);
        end
        total++;
        if (pv.size() != 1 || pv[0] !== 4'b1000) begin
            bad++; $display("FAIL flush got_n=%0d exp single 1000", pv.size());
        end
        btn_raw = 4'b0;
        tick(20);
    endtask

    task automatic test_gap_press;
        int pt[$];
        logic [3:0] pv[$];
        btn_raw = 4'b0100;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (k == 1) btn_raw = 4'b0101;
            if (bus.num_o !== 4'b0) begin pv.push_back(bus.num_o); pt.push_back(k); end
        end
        total++;
        if (pv.size() != 2 || {pv[0], pv[1]} !== 8'b0100_0001 || pt[1] - pt[0] != 2) begin
            bad++; $display("FAIL gap_press got_n=%0d exp 0100 then 0001 two cycles later", pv.size());
        end
        btn_raw = 4'b0;
        tick(20);
    endtask

    task automatic test_reset_mid;
        int lat = 0;
        int extra = 0;
        btn_raw = 4'b0001;
        while (bus.num_o === 4'b0 && lat < 30) begin
            tick();
            lat++;
        end
        total++; if (bus.num_o !== 4'b0001) begin bad++; $display("FAIL rstmid_pulse got=%b exp=0001", bus.num_o); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus.num_o !== 4'b0) begin bad++; $display("FAIL rstmid_num got=%b exp=0000", bus.num_o); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
        btn_raw = 4'b0;
        tick(2);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus.num_o !== 4'b0 || bus.busy !== 1'b0) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL rstmid_ghost got=%0d exp=0", extra); end
        btn_raw = 4'b0001;
        lat = 0;
        while (bus.num_o === 4'b0 && lat < 30) begin
            tick();
            lat++;
        end
        total++; if (lat !== 7) begin bad++; $display("FAIL rstmid_repress got=%0d exp=7", lat); end
        btn_raw = 4'b0;
        tick(20);
    endtask

    task automatic test_auto_repeat;
        int pt[$];
        int exp_t[$];
        int ok = 1;
`ifdef BTN_AUTO_REPEAT_EN
        exp_t = '{7, 15, 19, 23, 27, 31, 35};
`else
        exp_t = '{7};
`endif
        btn_raw = 4'b0001;
        for (int k = 1; k <= 50; k++) begin
            tick();
            if (k == 30) btn_raw = 4'b0;
            if (bus.num_o !== 4'b0) begin
                pt.push_back(k);
                if (bus.num_o !== 4'b0001) ok = 0;
            end
            total++; if (bus.num_o !== m_num) begin bad++; $display("FAIL repeat_model got=%b exp=%b", bus.num_o, m_num); end
        end
        total++; if (pt.size() != exp_t.size()) begin bad++; $display("FAIL repeat_count got=%0d exp=%0d", pt.size(), exp_t.size()); end
        for (int i = 0; i < exp_t.size() && i < pt.size(); i++) begin
            total++; if (pt[i] != exp_t[i]) begin bad++; $display("FAIL repeat_time%0d got=%0d exp=%0d", i, pt[i], exp_t[i]); end
        end
        total++; if (ok != 1) begin bad++; $display("FAIL repeat_value got=non-0001 exp=0001"); end
        tick(20);
    endtask

    task automatic test_random;
        int hold;
        for (int s = 0; s < 80; s++) begin
            btn_raw = ($urandom_range(0, 1) == 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            hold = $urandom_range(1, 14);
            for (int h = 0; h < hold; h++) begin
                tick();
                total++; if (bus.num_o !== m_num) begin bad++; $display("FAIL rand_num got=%b exp=%b", bus.num_o, m_num); end
                total++; if (bus.stable_o !== m_stable) begin bad++; $display("FAIL rand_stable got=%b exp=%b", bus.stable_o, m_stable); end
                total++;
                if (bus.busy !== ((cyc < m_next_ok) || (m_pend != 4'b0))) begin
                    bad++; $display("FAIL rand_busy got=%b exp=%b", bus.busy, (cyc < m_next_ok) || (m_pend != 4'b0));
                end
                total++; if ($countones(bus.num_o) > 1) begin bad++; $display("FAIL rand_onehot got=%b exp=at most one bit", bus.num_o); end
            end
        end
        btn_raw = 4'b0;
        tick(40);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rand_drain got=%b exp=0", bus.busy); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_bounce;
        test_simultaneous;
        test_gap_press;
        test_reset_mid;
        test_auto_repeat;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/btn_pulse_gen.md
Name: btn_pulse_gen

Overview:
- Front-end for the calculator's `num_i[3:0]` command bus: the producing end of that interface.
- Takes the four raw, bouncy push-buttons and synchronises and debounces each one.
- Converts each press into a single one-hot, one-cycle pulse on `num_o`, with a guaranteed idle gap between pulses.
- Bit map: bit0 = increment, bit1 = alt-confirm, bit2 = next/confirm, bit3 = reset. Sits between the board pins and the `seg7` calculator core.

Parameters:
- DB_CYCLES, 16: consecutive stable cycles required before a debounced level changes (>=2).
- GAP_CYCLES, 1: minimum all-zero cycles on `num_o` after every pulse (>=1).
- RPT_DELAY, 64: cycles bit0 must be held before the first auto-repeat (optional feature only).
- RPT_PERIOD, 16: cycles between auto-repeats while bit0 stays held (optional feature only).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- btn_raw  in  4  raw button levels, asynchronous, active-high
- num_o  out  4  one-hot command pulse, at most one bit high, high for exactly 1 cycle
- busy  out  1  high in PULSE/GAP, or whenever any press is pending
- stable_o  out  4  debounced button levels (status/LED use)

Behaviour:
- Clocking and reset:
  - One clock, `clk`. Reset is asynchronous and active-low (`rst_n`); all flops are cleared on reset.
  - Outputs during and after reset: `num_o`=0, `busy`=0, `stable_o`=0.
  - Internal state cleared by reset: synchronisers, debounce counters, pending flags, FSM=IDLE.
  - Reset mid-pulse aborts immediately; no pending press survives reset.
- Synchroniser: 2-flop per bit; `sync[i]` lags `btn_raw[i]` by 2 cycles.
- Debounce, per bit:
  - Counter width `$clog2(DB_CYCLES+1)`.
  - While `sync[i]` != `stable[i]`, the counter increments. When it reaches DB_CYCLES-1, `stable[i]` toggles on that edge and the counter clears.
  - Any cycle with `sync[i]` == `stable[i]` clears the counter.
  - Press-to-stable latency: 2 + DB_CYCLES cycles.
- Pending flags:
  - A rising edge of `stable[i]` sets `pend[i]`. Falling edges are ignored.
  - If a set and a clear of the same flag coincide, set wins.
- Output FSM (IDLE, PULSE, GAP):
  - IDLE: if any `pend` is set, select by priority bit3 > bit2 > bit1 > bit0. Load the selected one-hot into `num_o` (registered), clear that `pend` bit, then go to PULSE.
  - Selecting bit3 additionally clears `pend[2:0]`, so stale commands are flushed by reset.
  - PULSE: `num_o` holds the one-hot for exactly one cycle, then goes to GAP. A gap counter loads GAP_CYCLES-1.
  - GAP: `num_o`=0. The counter decrements; at 0 the FSM returns to IDLE.
  - Pending-to-`num_o` latency: 1 cycle from IDLE.
  - Pulse spacing: back-to-back pulses are exactly 1+GAP_CYCLES cycles apart.
- Simultaneous events:
  - Simultaneous presses are all queued and emitted in priority order.
  - A repeat press of the same button while its flag is already set is merged (one pulse).
- `busy` = (state != IDLE) | (|pend).

Optional Feature:
- Macro: BTN_AUTO_REPEAT_EN.
- When defined:
  - While `stable[0]` stays high, a hold counter runs. At RPT_DELAY cycles after the rising edge it sets `pend[0]`.
  - After that it sets `pend[0]` every RPT_PERIOD cycles.
  - The counter clears when `stable[0]` falls. A bit3 selection also clears the counter and restarts the delay.
- When undefined: no hold counter; one press gives one pulse regardless of hold time. RPT_DELAY and RPT_PERIOD are unused.

Test Plan:
- Common bench setting: DB_CYCLES=4, GAP_CYCLES=1.
- Single bit0 press:
  - Stimulus: `btn_raw`=0001 held 20 cycles, then released.
  - Required: `num_o`=0001 for exactly 1 cycle, first seen 7 cycles after the press edge (2 sync + 4 debounce + 1 FSM); no second pulse.
- Bounce rejection:
  - Stimulus: `btn_raw[0]` toggles every 2 cycles for 12 cycles, then stays 0.
  - Required: `num_o` stays 0000; `stable_o` stays 0000.
- Simultaneous press and flush:
  - Stimulus: 0111 pressed together.
  - Required: pulses 0100, 0010, 0001, each 2 cycles apart.
  - Stimulus: 1111 pressed together.
  - Required: a single pulse 1000 only.
- Press during GAP:
  - Stimulus: bit2 pulse, with a bit0 press whose debounce completes in the GAP cycle.
  - Required: 0001 emitted in the cycle right after GAP ends.
- Reset mid-operation:
  - Stimulus: assert `rst_n`=0 asynchronously during PULSE.
  - Required: `num_o`=0000 immediately; `busy`=0; after release, no pulse until a new press.
- Auto-repeat (with BTN_AUTO_REPEAT_EN, RPT_DELAY=8, RPT_PERIOD=4):
  - Stimulus: hold bit0 for 30 cycles after `stable[0]` rises.
  - Required: an initial pulse, then repeats at 8, 12, 16, 20, 24, 28 cycles after the rise (+1 FSM latency each).
  - Required without the macro: exactly one pulse.
